// File: rtl/dmem_responder.sv
// MEM-stage data memory: byte/half/word stores, extended loads, fault and access status.
// Define DMEM_MISALIGN_CHECK_EN to fault and suppress misaligned word/half accesses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  dm_type,
   input  logic        err_clr,
   output logic [31:0] rdata,
   output logic        err_valid,
   output logic [31:0] err_addr,
   output logic [3:0]  err_info,
   output logic [31:0] ld_cnt,
   output logic [31:0] st_cnt
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0] idx_w;
   logic          is_w, is_h, is_hu, is_b, is_bu, is_rsv;
   logic          is_half, is_byte;
   logic          misal_w, supp_w, fault_w;
   logic [3:0]    be_w;
   logic [31:0]   wlane_w;
   logic [31:0]   rd_word_w;
   logic [15:0]   rd_half_w;
   logic [7:0]    rd_byte_w;
   logic          unused_addr_w;

   logic          err_valid_q, err_valid_d;
   logic [31:0]   err_addr_q, err_addr_d;
   logic [3:0]    err_info_q, err_info_d;
   logic [31:0]   ld_cnt_q;
   logic [31:0]   st_cnt_q;

   assign idx_w         = addr[AW+1:2];
   assign unused_addr_w = ^addr[31:AW+2];

   assign is_w    = (dm_type == 3'b000);
   assign is_h    = (dm_type == 3'b001);
   assign is_hu   = (dm_type == 3'b010);
   assign is_b    = (dm_type == 3'b011);
   assign is_bu   = (dm_type == 3'b100);
   assign is_rsv  = (dm_type[2] & (dm_type[1:0] != 2'b00));
   assign is_half = is_h | is_hu;
   assign is_byte = is_b | is_bu;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misal_w = (is_w & (addr[1:0] != 2'b00)) | (is_half & addr[0]);
`else
   assign misal_w = 1'b0;
`endif

   assign supp_w  = is_rsv | misal_w;
   assign fault_w = (mem_we | mem_re) & supp_w;

   always_comb begin
      be_w    = 4'b0000;
      wlane_w = wdata;
      unique case (1'b1)
         is_w:    be_w = 4'b1111;
         is_half: begin
            be_w    = 4'b0011 << {addr[1], 1'b0};
            wlane_w = {2{wdata[15:0]}};
         end
         is_byte: begin
            be_w    = 4'b0001 << addr[1:0];
            wlane_w = {4{wdata[7:0]}};
         end
         is_rsv:  be_w = 4'b0000;
      endcase
      if (supp_w) be_w = 4'b0000;
   end

   // Array is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_w[b]) mem_q[idx_w][8*b +: 8] <= wlane_w[8*b +: 8];
         end
      end
   end

   assign rd_word_w = mem_q[idx_w];
   assign rd_half_w = addr[1] ? rd_word_w[31:16] : rd_word_w[15:0];
   assign rd_byte_w = rd_word_w[{addr[1:0], 3'b000} +: 8];

   always_comb begin
      rdata = 32'h0;
      unique case (1'b1)
         is_w:   rdata = rd_word_w;
         is_h:   rdata = {{16{rd_half_w[15]}}, rd_half_w};
         is_hu:  rdata = {16'h0, rd_half_w};
         is_b:   rdata = {{24{rd_byte_w[7]}}, rd_byte_w};
         is_bu:  rdata = {24'h0, rd_byte_w};
         is_rsv: rdata = 32'h0;
      endcase
      if (misal_w) rdata = 32'h0;
   end

   // A fault on the clearing edge is latched as a fresh first fault.
   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_info_d  = err_info_q;
      if (err_clr) err_valid_d = 1'b0;
      if (fault_w && (!err_valid_q || err_clr)) begin
         err_valid_d = 1'b1;
         err_addr_d  = addr;
         err_info_d  = {mem_we, dm_type};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= 32'h0;
         err_info_q  <= 4'h0;
         ld_cnt_q    <= 32'h0;
         st_cnt_q    <= 32'h0;
      end else begin
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_info_q  <= err_info_d;
         if (mem_re && !mem_we) ld_cnt_q <= ld_cnt_q + 32'd1;
         if (mem_we && !supp_w) st_cnt_q <= st_cnt_q + 32'd1;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_info  = err_info_q;
   assign ld_cnt    = ld_cnt_q;
   assign st_cnt    = st_cnt_q;

endmodule
